rv32i_load_store_unit: RTL and testbench

//  MEM-stage data-memory access unit; produces the memory data consumed by the WB select (WB_SEL_MEM).

---
 rtl/rv32i_load_store_unit_pkg.sv | 58 +++++
 rtl/rv32i_load_align.sv | 27 ++
 rtl/rv32i_load_store_unit.sv | 114 +++++++++++
 tb/tb_rv32i_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_load_store_unit_pkg.sv
// Shared funct3 encodings, LSU state encoding and store-lane helpers for the load/store unit.
// Pure definitions: no latency, no flow control.
package rv32i_load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_WAIT = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  // Legal funct3 for the op direction and naturally aligned for its size.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~a[0];
      F3_LW:   ok = (a == 2'b00);
      F3_LBU:  ok = ~is_store;
      F3_LHU:  ok = ~is_store & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [LSU_XLEN-1:0] lane_wdata(input logic [1:0] size,
                                                     input logic [LSU_XLEN-1:0] d);
    logic [LSU_XLEN-1:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load data aligner: picks the addressed byte/half lane of the read word and sign/zero-extends it.
// Combinational, zero latency; no flow control.
module rv32i_load_align
  import rv32i_load_store_unit_pkg::*;
(
  input  logic [LSU_XLEN-1:0] i_rdata,
  input  logic [1:0]          i_byte_off,
  input  logic [2:0]          i_funct3,
  output logic [LSU_XLEN-1:0] o_data
);

  logic [LSU_XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// MEM-stage load/store unit on a req/gnt/rvalid bus; store 3 cycles, load 3-4 cycles incl. DONE.
// Stalls the pipeline from issue until the access completes; misaligned ops rejected without stalling.
module rv32i_load_store_unit
  import rv32i_load_store_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [XLEN-1:0]       i_store_data,
  output logic                  o_stall,
  output logic [XLEN-1:0]       o_load_data,
  output logic                  o_load_valid,
  output logic                  o_misaligned,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [XLEN-1:0]       o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [XLEN-1:0]       i_mem_rdata
);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [XLEN-1:0]       r_wdata;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_load_data;

  logic                  w_mem_op;
  logic                  w_ok;
  logic                  w_idle;
  logic                  w_start;
  logic                  w_bad;
  logic                  w_capture;
  logic [XLEN-1:0]       w_aligned;

  assign w_mem_op  = i_valid & (i_mem_read | i_mem_write);
  assign w_ok      = access_ok(i_mem_write, i_funct3, i_addr[1:0]);
  assign w_idle    = (r_state == LSU_IDLE);
  // Gated by reset so IDLE-state combinational outputs read 0 while reset is held.
  assign w_start   = i_rst_n & w_idle & w_mem_op & w_ok;
  assign w_bad     = i_rst_n & w_idle & w_mem_op & ~w_ok;
  assign w_capture = i_mem_rvalid & ~r_we &
                     (((r_state == LSU_REQ) & i_mem_gnt) | (r_state == LSU_WAIT));

  rv32i_load_align u_load_align (
    .i_rdata    (i_mem_rdata),
    .i_byte_off (r_addr[1:0]),
    .i_funct3   (r_funct3),
    .o_data     (w_aligned)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= LSU_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_start) begin
            r_state  <= LSU_REQ;
            r_addr   <= i_addr;
            r_we     <= i_mem_write;
            r_be     <= byte_en(i_funct3[1:0], i_addr[1:0]);
            r_wdata  <= lane_wdata(i_funct3[1:0], i_store_data);
            r_funct3 <= i_funct3;
          end
        end
        LSU_REQ: begin
          if (i_mem_gnt) begin
            r_state <= (r_we | i_mem_rvalid) ? LSU_DONE : LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (i_mem_rvalid) r_state <= LSU_DONE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_data <= '0;
    end else if (w_capture) begin
      r_load_data <= w_aligned;
    end
  end

  assign o_stall      = w_start | (r_state == LSU_REQ) | (r_state == LSU_WAIT);
  assign o_misaligned = w_bad;
  assign o_load_valid = (r_state == LSU_DONE) & ~r_we;
  assign o_load_data  = r_load_data;
  assign o_mem_req    = (r_state == LSU_REQ);
  assign o_mem_we     = r_we;
  assign o_mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata  = r_wdata;
  assign o_mem_be     = r_be;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed bench for rv32i_load_store_unit: stores, loads, rejects, stalled grant, mid-access reset.
module tb_rv32i_load_store_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_misaligned;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int total = 0;
  int bad   = 0;

  rv32i_load_store_unit #(.XLEN(32), .ADDR_WIDTH(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_misaligned (o_misaligned),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expd);
    end
  endtask

  task automatic clear_op();
    i_valid      = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    i_funct3     = 3'b000;
    i_addr       = 32'h0;
    i_store_data = 32'h0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                           input logic [31:0] hold_data);
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_write = 1'b1; i_funct3 = f3; i_addr = addr; i_store_data = data;
    #1;
    chk({tag, "_stall_c1"}, o_stall, 1);
    chk({tag, "_req_c1"}, o_mem_req, 0);
    @(negedge i_clk);
    clear_op();
    i_mem_gnt = 1'b1;
    #1;
    chk({tag, "_req_c2"}, o_mem_req, 1);
    chk({tag, "_we"}, o_mem_we, 1);
    chk({tag, "_be"}, o_mem_be, exp_be);
    chk({tag, "_addr"}, o_mem_addr, exp_addr);
    chk({tag, "_wdata"}, o_mem_wdata, exp_wdata);
    chk({tag, "_stall_c2"}, o_stall, 1);
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    #1;
    chk({tag, "_stall_done"}, o_stall, 0);
    chk({tag, "_req_done"}, o_mem_req, 0);
    chk({tag, "_lv_done"}, o_load_valid, 0);
    chk({tag, "_ldata_hold"}, o_load_data, hold_data);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] expd, input bit late);
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = f3; i_addr = addr;
    #1;
    chk({tag, "_stall_c1"}, o_stall, 1);
    chk({tag, "_lv_c1"}, o_load_valid, 0);
    @(negedge i_clk);
    clear_op();
    i_mem_gnt = 1'b1;
    if (!late) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata;
    end
    #1;
    chk({tag, "_req"}, o_mem_req, 1);
    chk({tag, "_we"}, o_mem_we, 0);
    chk({tag, "_addr"}, o_mem_addr, {addr[31:2], 2'b00});
    if (late) begin
      @(negedge i_clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
      #1;
      chk({tag, "_req_wait"}, o_mem_req, 0);
      chk({tag, "_stall_wait"}, o_stall, 1);
      chk({tag, "_lv_wait"}, o_load_valid, 0);
    end
    @(negedge i_clk);
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    #1;
    chk({tag, "_lv_done"}, o_load_valid, 1);
    chk({tag, "_data"}, o_load_data, expd);
    chk({tag, "_stall_done"}, o_stall, 0);
    @(negedge i_clk);
    #1;
    chk({tag, "_lv_after"}, o_load_valid, 0);
    chk({tag, "_data_hold"}, o_load_data, expd);
  endtask

  task automatic run_bad(input string tag, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr);
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = ~rd; i_funct3 = f3; i_addr = addr;
    i_store_data = 32'h1234_5678;
    #1;
    chk({tag, "_mis"}, o_misaligned, 1);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_req"}, o_mem_req, 0);
    @(negedge i_clk);
    #1;
    chk({tag, "_req_next"}, o_mem_req, 0);
    chk({tag, "_mis_next"}, o_misaligned, 1);
    @(negedge i_clk);
    clear_op();
    #1;
    chk({tag, "_mis_clear"}, o_misaligned, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    clear_op();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    #12;
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_lv", o_load_valid, 0);
    chk("rst_ldata", o_load_data, 0);
    chk("rst_mis", o_misaligned, 0);
    chk("rst_be", o_mem_be, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h100, 32'h0);
    run_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h100, 32'h0);
    run_store("sh", 3'b001, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h100, 32'h0);

    run_load("lb",  3'b000, 32'h102, 32'h1280_3456, 32'hFFFF_FF80, 1'b1);
    run_load("lbu", 3'b100, 32'h102, 32'h1280_3456, 32'h0000_0080, 1'b1);
    run_load("lh",  3'b001, 32'h102, 32'h8001_1234, 32'hFFFF_8001, 1'b0);
    run_load("lhu", 3'b101, 32'h102, 32'h8001_1234, 32'h0000_8001, 1'b0);
    run_load("lw",  3'b010, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

    run_store("sw_hold", 3'b010, 32'h108, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 32'h108,
              32'hCAFE_F00D);

    run_bad("lh_odd", 1'b1, 3'b001, 32'h101);
    run_bad("lw_off2", 1'b1, 3'b010, 32'h102);
    run_bad("ld_f3_3", 1'b1, 3'b011, 32'h100);
    run_bad("st_f3_4", 1'b0, 3'b100, 32'h100);
    run_bad("sh_odd", 1'b0, 3'b001, 32'h103);

    // Grant withheld for five REQ cycles.
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      clear_op();
      #1;
      chk($sformatf("gnt_lo_req_%0d", k), o_mem_req, 1);
      chk($sformatf("gnt_lo_addr_%0d", k), o_mem_addr, 32'h200);
      chk($sformatf("gnt_lo_we_%0d", k), o_mem_we, 0);
      chk($sformatf("gnt_lo_be_%0d", k), o_mem_be, 4'b1111);
      chk($sformatf("gnt_lo_stall_%0d", k), o_stall, 1);
    end
    @(negedge i_clk);
    i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5566_7788;
    #1;
    chk("gnt_hi_req", o_mem_req, 1);
    @(negedge i_clk);
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    #1;
    chk("gnt_hi_lv", o_load_valid, 1);
    chk("gnt_hi_data", o_load_data, 32'h5566_7788);
    chk("gnt_hi_stall", o_stall, 0);

    // Reset asserted while waiting for read data.
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h300;
    @(negedge i_clk);
    clear_op();
    i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    #1;
    chk("rstw_stall_pre", o_stall, 1);
    chk("rstw_req_pre", o_mem_req, 0);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rstw_stall", o_stall, 0);
    chk("rstw_req", o_mem_req, 0);
    chk("rstw_lv", o_load_valid, 0);
    chk("rstw_ldata", o_load_data, 0);
    chk("rstw_addr", o_mem_addr, 0);
    chk("rstw_be", o_mem_be, 0);
    chk("rstw_wdata", o_mem_wdata, 0);
    chk("rstw_we", o_mem_we, 0);
    chk("rstw_mis", o_misaligned, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_lv0", o_load_valid, 0);
    chk("stray_req", o_mem_req, 0);
    @(negedge i_clk);
    i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    #1;
    chk("stray_lv1", o_load_valid, 0);
    chk("stray_ldata", o_load_data, 0);
    chk("stray_stall", o_stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
